// File: rtl/tlb_req_pipe.sv
// rtl/tlb_req_pipe.sv - TLB-to-L2 request FIFO with in-flight tracking, flush staling and delayed response pipe
//
// Ports:
//   clk, rst (async, active-low), flush
//   in_req_*      TLB-side request handshake and payload (addr, info)
//   out_req_*     L2-side request handshake and payload
//   out_rsp_*     L2 response strobe and payload, no backpressure, in issue order
//   in_rsp_*      response to the TLB, RSP_STAGES cycles after out_rsp_valid
//   stale_drops   saturating count of responses discarded because of a flush
module tlb_req_pipe #(
  parameter int VADDR_W    = 39,
  parameter int INFO_W     = 8,
  parameter int ENTRY_W    = 64,
  parameter int REQ_DEPTH  = 4,
  parameter int RSP_STAGES = 1,
  parameter int MAX_OUT    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_req_valid,
  output logic               in_req_ready,
  input  logic [VADDR_W-1:0] in_req_addr,
  input  logic [INFO_W-1:0]  in_req_info,
  output logic               out_req_valid,
  input  logic               out_req_ready,
  output logic [VADDR_W-1:0] out_req_addr,
  output logic [INFO_W-1:0]  out_req_info,
  input  logic               out_rsp_valid,
  input  logic               out_rsp_error,
  input  logic               out_rsp_exception,
  input  logic [INFO_W-1:0]  out_rsp_info,
  input  logic [ENTRY_W-1:0] out_rsp_entry,
  output logic               in_rsp_valid,
  output logic               in_rsp_error,
  output logic               in_rsp_exception,
  output logic [INFO_W-1:0]  in_rsp_info,
  output logic [ENTRY_W-1:0] in_rsp_entry,
  output logic [15:0]        stale_drops
);

  localparam int PTR_W = $clog2(REQ_DEPTH);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int REQ_W = VADDR_W + INFO_W;
  localparam int RSP_W = 2 + INFO_W + ENTRY_W;
  localparam logic [PTR_W:0] DEPTH_C   = (PTR_W+1)'(REQ_DEPTH);
  localparam logic [CNT_W:0] MAX_OUT_C = (CNT_W+1)'(MAX_OUT);

  // Request FIFO
  logic [REQ_W-1:0] mem [REQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, enq, deq;

  // In-flight tracking: live responses will be forwarded, stale ones dropped
  logic [CNT_W-1:0] live, stale;
  logic [CNT_W:0]   inflight;
  logic             rsp_any, rsp_drop, rsp_fwd;

  // Response pipeline
  logic             vld_q [RSP_STAGES];
  logic [RSP_W-1:0] pay_q [RSP_STAGES];

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign inflight = {1'b0, live} + {1'b0, stale};

  // Reset terms keep the handshake outputs at their reset values even if flush is high
  assign in_req_ready  = !rst || (!full && !flush);
  assign out_req_valid = rst && !empty && (inflight < MAX_OUT_C) && !flush;
  assign enq           = in_req_valid && in_req_ready;
  assign deq           = out_req_valid && out_req_ready;

  assign {out_req_addr, out_req_info} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= {in_req_addr, in_req_info};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, deq};
    end
  end

  // A response with nothing outstanding is ignored outright. Responses return in
  // issue order and stale requests are always older than live ones, so stale ones
  // are consumed first.
  assign rsp_any  = out_rsp_valid && (inflight != '0);
  assign rsp_drop = rsp_any && (flush || (stale != '0));
  assign rsp_fwd  = rsp_any && !flush && (stale == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live        <= '0;
      stale       <= '0;
      stale_drops <= '0;
    end else begin
      if (flush) begin
        // No issue can happen in a flush cycle, so only the coinciding response matters
        live  <= '0;
        stale <= stale + live - CNT_W'(rsp_any);
      end else begin
        live  <= live + CNT_W'(deq) - CNT_W'(rsp_fwd);
        stale <= stale - CNT_W'(rsp_drop);
      end
      if (rsp_drop && (stale_drops != 16'hFFFF)) stale_drops <= stale_drops + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RSP_STAGES; i++) vld_q[i] <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < RSP_STAGES; i++) vld_q[i] <= 1'b0;
    end else begin
      vld_q[0] <= rsp_fwd;
      for (int i = 1; i < RSP_STAGES; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Payload only travels alongside the valid bits, so it needs no reset
  always_ff @(posedge clk) begin
    pay_q[0] <= {out_rsp_error, out_rsp_exception, out_rsp_info, out_rsp_entry};
    for (int i = 1; i < RSP_STAGES; i++) pay_q[i] <= pay_q[i-1];
  end

  assign in_rsp_valid = vld_q[RSP_STAGES-1];
  assign {in_rsp_error, in_rsp_exception, in_rsp_info, in_rsp_entry} = pay_q[RSP_STAGES-1];

endmodule
